deserialiser_block: RTL and testbench
=====================================

// Module: deserialiser_block
// PURPOSE
//  Receive side of the 32-bit word serial link: collects 16 serial words and
//  rebuilds one 4x4 word_t state/keystream matrix.
//  Sits after Serialiser-fed paths (e.g. keystream into the XOR/Poly1305 stage).
//  Arrival order matches the link order: first word lands in [3][3], then [3][2],
//  and so on down to [0][0].
//  Valid/ready on both sides. Single block buffer, with accept-on-drain.
// PARAMETERS
//  WORDS_PER_BLK  16  words per matrix; fixed at 4x4, and elaboration fails if it differs
//  (word width comes from word_t, 32 bits, in the shared package)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  clear      in   1        sync abort: drop partial/held block
//  in_word    in   32       serial word (word_t)
//  in_valid   in   1        in_word valid
//  in_ready   out  1        block can accept in_word this cycle
//  out_block  out  16x32    rebuilt matrix, word_t [3:0][3:0]
//  out_valid  out  1        out_block complete and held
//  out_ready  in   1        consumer takes out_block this cycle
//  fill_cnt   out  4        words accepted into the current block (0..15)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=FILL, fill_cnt=0, out_valid=0, out_block all 0.
//   - in_ready=0 while rst is high.
//  States:
//   - FILL: in_ready=1.
//   - FULL: out_valid=1; in_ready=out_ready (combinational).
//  Accept:
//   - acc = in_valid & in_ready.
//   - On acc, write out_block[3-fill_cnt[3:2]][3-fill_cnt[1:0]] <= in_word.
//   - On acc, fill_cnt increments mod 16.
//  FILL -> FULL:
//   - Taken on an acc with fill_cnt==15; fill_cnt wraps to 0.
//   - out_valid rises the cycle after the 16th accept (latency 1 clk).
//  FULL, out_ready=0:
//   - out_block, out_valid and fill_cnt hold. No writes.
//   - in_word is ignored even if in_valid=1.
//  FULL, out_ready=1:
//   - Handshake completes; state -> FILL and out_valid=0 next cycle.
//   - If in_valid is also 1 that cycle, the word is accepted and written to
//     [3][3] of the next block (fill_cnt->1).
//   - The consumer samples the old matrix on the same edge.
//  out_block is not cleared between blocks; words not yet overwritten are stale
//  until out_valid.
//  clear (highest priority after rst):
//   - Next cycle: state=FILL, fill_cnt=0, out_valid=0. out_block unchanged.
//   - Any same-cycle acc is discarded.
//  in_valid with no acc: no state change. Source holds the word (link contract).
//  out_valid is registered. in_ready is combinational from state, out_ready and rst only.
// STRUCTURE
//  Shared package (chacha_pkg):
//   - word_t (logic [31:0]).
//   - state_mtx_t = word_t [3:0][3:0].
//   - localparam BLK_WORDS=16.
//  In-file enum: deser_state_t {FILL, FULL}.
//  No sub-module required.
//  Index decode row=3-cnt[3:2], col=3-cnt[1:0] goes as a package function
//  blk_idx(), shared with the transmit side.
// TESTING
//  1. Basic fill:
//     - Stimulus: feed 0x00..0x0F back-to-back, out_ready=0.
//     - Response: out_valid=1 one clk after the 16th accept.
//     - out_block [3][3]=0x0, [3][0]=0x3, [0][0]=0xF.
//  2. Loopback:
//     - Stimulus: load Serialiser with matrix m[r][c]=0xA0+4r+c, drive in_valid=validS.
//     - Response: out_block==m; no extra accepts.
//  3. Backpressure:
//     - Stimulus: block full, out_ready=0 for 5 clks, in_valid=1 with 0xDEAD.
//     - Response: in_ready=0 throughout; out_block and fill_cnt=0 unchanged.
//  4. Drain and accept in one cycle:
//     - Stimulus: FULL, out_ready=1, in_valid=1, word 0x55.
//     - Response: next clk out_valid=0, fill_cnt=1, out_block[3][3]=0x55.
//  5. Clear mid-block:
//     - Stimulus: 7 words, then clear with in_valid=1 in the same cycle, then 16 words 0x10..0x1F.
//     - Response: fill_cnt=0 after clear; final block [3][3]=0x10, [0][0]=0x1F.
//  6. Reset mid-fill:
//     - Stimulus: assert rst asynchronously (between edges) after 9 words.
//     - Response: out_valid=0, fill_cnt=0 and out_block=0 immediately; in_ready=0 until rst released.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared types for the 32-bit word serial link and the 4x4 ChaCha state matrix.
//   word_t       - one 32-bit link word
//   state_mtx_t  - 4x4 matrix of words, indexed [row][col]
//   blk_idx()    - maps a word count (0..15) to its matrix position in link order
package chacha_pkg;

    localparam int unsigned BLK_WORDS = 16;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] state_mtx_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } blk_pos_t;

    // Link order runs from [3][3] down to [0][0].
    function automatic blk_pos_t blk_idx(input logic [3:0] cnt);
        blk_pos_t pos;
        pos.row = 2'd3 - cnt[3:2];
        pos.col = 2'd3 - cnt[1:0];
        return pos;
    endfunction

endpackage

// File: rtl/deserialiser_block_if.sv
// Handshake bundle for the deserialiser: serial word input, block output, abort
// and fill status.
//   master - the environment (word source + block consumer)
//   slave  - the deserialiser itself
interface deserialiser_block_if;
    import chacha_pkg::*;

    logic       clear;
    word_t      in_word;
    logic       in_valid;
    logic       in_ready;
    state_mtx_t out_block;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] fill_cnt;

    modport master (
        output clear, in_word, in_valid, out_ready,
        input  in_ready, out_block, out_valid, fill_cnt
    );

    modport slave (
        input  clear, in_word, in_valid, out_ready,
        output in_ready, out_block, out_valid, fill_cnt
    );

endinterface

// File: rtl/deserialiser_block.sv
// Collects 16 serial words into one 4x4 word matrix. The first word lands in
// [3][3], the last in [0][0]. Single block buffer: while the block is held
// (out_valid) input is stalled, except on the drain cycle where a new word may
// be accepted into the next block.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of deserialiser_block_if (clear, in_*, out_*, fill_cnt)
module deserialiser_block
    import chacha_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLK = 16
) (
    input  logic               clk,
    input  logic               rst,
    deserialiser_block_if.slave bus
);

    if (WORDS_PER_BLK != BLK_WORDS) begin : g_bad_blk_size
        $error("deserialiser_block: WORDS_PER_BLK must be 16");
    end

    typedef enum logic [0:0] {FILL, FULL} deser_state_t;

    deser_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    state_mtx_t   blk_q, blk_d;
    logic         acc;
    blk_pos_t     pos;

    // in_ready depends only on state, out_ready and rst so a source can never
    // see a combinational loop through in_valid.
    assign bus.in_ready  = ~rst & ((state_q == FILL) | bus.out_ready);
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_block = blk_q;
    assign bus.fill_cnt  = cnt_q;

    assign acc = bus.in_valid & bus.in_ready;
    assign pos = blk_idx(cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        if (bus.clear) begin
            // Abort drops the partial or held block; stored words stay stale.
            state_d = FILL;
            cnt_d   = 4'd0;
        end else begin
            if ((state_q == FULL) && bus.out_ready) begin
                state_d = FILL;
            end
            if (acc) begin
                blk_d[pos.row][pos.col] = bus.in_word;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FULL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= 4'd0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_deserialiser_block.sv
module tb_deserialiser_block;
    import chacha_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    deserialiser_block_if bus ();

    deserialiser_block #(
        .WORDS_PER_BLK (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    state_mtx_t exp_blk;
    state_mtx_t m;
    state_mtx_t snap;
    int         k;
    int         cyc;
    logic       acc_now;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.in_word = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        bus.in_valid = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_fill_cnt", bus.fill_cnt, 0);
        chk("rst_out_block", bus.out_block, 0);
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // 1. Basic fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word = 32'(i);
            if (i == 15) begin
                chk("fill_cnt_15", bus.fill_cnt, 15);
                chk("valid_before_16th", bus.out_valid, 0);
            end
            step();
        end
        chk("fill_out_valid", bus.out_valid, 1);
        chk("fill_cnt_wrap", bus.fill_cnt, 0);
        chk("fill_b33", bus.out_block[3][3], 32'h0);
        chk("fill_b30", bus.out_block[3][0], 32'h3);
        chk("fill_b00", bus.out_block[0][0], 32'hF);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_blk[r][c] = 32'(15 - 4 * r - c);
        chk("fill_block", bus.out_block, exp_blk);

        // 3. Backpressure
        bus.in_word = 32'hDEAD;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", bus.in_ready, 0);
            step();
            chk("bp_fill_cnt", bus.fill_cnt, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_block", bus.out_block, exp_blk);
        end

        // 4. Drain and accept in one cycle
        bus.in_word = 32'h55;
        bus.out_ready = 1'b1;
        #1;
        chk("drain_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("drain_out_valid", bus.out_valid, 0);
        chk("drain_fill_cnt", bus.fill_cnt, 1);
        chk("drain_b33", bus.out_block[3][3], 32'h55);
        chk("drain_b00_stale", bus.out_block[0][0], 32'hF);

        // 5. Clear mid-block: 7 words in total, then clear with a same-cycle word
        for (int i = 1; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word = 32'h60 + 32'(i);
            step();
        end
        chk("pre_clear_cnt", bus.fill_cnt, 7);
        bus.in_word = 32'h99;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear_fill_cnt", bus.fill_cnt, 0);
        chk("clear_out_valid", bus.out_valid, 0);
        chk("clear_b20_untouched", bus.out_block[2][0], 32'h7);
        chk("clear_b23_kept", bus.out_block[2][3], 32'h64);
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word = 32'h10 + 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("clr_blk_valid", bus.out_valid, 1);
        chk("clr_blk_b33", bus.out_block[3][3], 32'h10);
        chk("clr_blk_b00", bus.out_block[0][0], 32'h1F);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("clr_drained", bus.out_valid, 0);
        chk("clr_drained_cnt", bus.fill_cnt, 0);

        // 2. Loopback from a serialiser-like source with gaps in validS
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = 32'hA0 + 32'(4 * r + c);
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            bus.in_valid = (cyc % 3 != 2);
            bus.in_word = m[3 - k / 4][3 - k % 4];
            #1;
            acc_now = bus.in_valid & bus.in_ready;
            step();
            if (acc_now) k++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("loop_budget", k, 16);
        for (int i = 0; i < 3; i++) step();
        chk("loop_valid", bus.out_valid, 1);
        chk("loop_no_extra", bus.fill_cnt, 0);
        chk("loop_block", bus.out_block, m);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("loop_drained", bus.out_valid, 0);

        // 6. Async reset after 9 words
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word = 32'hC0 + 32'(i);
            step();
        end
        chk("pre_rst_cnt", bus.fill_cnt, 9);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fill_cnt", bus.fill_cnt, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_block", bus.out_block, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        step();
        chk("arst_hold_in_ready", bus.in_ready, 0);
        chk("arst_hold_cnt", bus.fill_cnt, 0);
        rst = 1'b0;
        #1;
        chk("arst_release_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
